circuit4_hlsm: RTL and testbench

Multi-cycle, FSM-scheduled counterpart of the single-pass circuit4 datapath. The block computes the same z/x function from 64-bit operands a, b, c behind a Start/Done handshake. It latches operands on Start, runs one operation group per state through a shared 64-bit add/sub unit and comparator, then presents registered 32-bit results. It sits between the operand-issuing controller and the result consumer in the scheduled-datapath flow.

---
 rtl/circuit4_hlsm_if.sv | 23 ++
 rtl/circuit4_hlsm.sv | 114 +++++++++++
 tb/tb_circuit4_hlsm.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/circuit4_hlsm_if.sv
// Start/Done handshake bundle for circuit4_hlsm:
// operands in, truncated 32-bit results out.
interface circuit4_hlsm_if #(
  parameter int DATAWIDTH = 64
);
  logic                 Start;
  logic [DATAWIDTH-1:0] a;
  logic [DATAWIDTH-1:0] b;
  logic [DATAWIDTH-1:0] c;
  logic [31:0]          z;
  logic [31:0]          x;
  logic                 Done;

  modport master (
    output Start, a, b, c,
    input  z, x, Done
  );

  modport slave (
    input  Start, a, b, c,
    output z, x, Done
  );
endinterface

// File: rtl/circuit4_hlsm.sv
// circuit4_hlsm: FSM-scheduled z/x datapath behind a Start/Done handshake.
// Define CIRCUIT4_HLSM_BUSY_EN to add the Busy status output.
module circuit4_hlsm #(
  parameter int DATAWIDTH = 64
) (
  input  logic Clk,
  input  logic Rst,
  circuit4_hlsm_if.slave bus
`ifdef CIRCUIT4_HLSM_BUSY_EN
  ,
  output logic Busy
`endif
);
  typedef enum logic [2:0] {
    WAIT,
    S1,
    S2,
    S3,
    S4,
    S5,
    FINAL
  } state_t;

  state_t state;
  state_t state_n;

  logic [DATAWIDTH-1:0] ar, br, cr;
  logic [DATAWIDTH-1:0] d, e, f, g, h;
  logic                 dLTe, dEQe;
  logic [31:0]          z, x;

  logic [DATAWIDTH-1:0] opb, alu, gsel;
  logic [31:0]          shl, shr;
  logic                 sub;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) state <= WAIT;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      WAIT:    if (bus.Start) state_n = S1;
      S1:      state_n = S2;
      S2:      state_n = S3;
      S3:      state_n = S4;
      S4:      state_n = S5;
      S5:      state_n = FINAL;
      FINAL:   state_n = WAIT;
      default: state_n = WAIT;
    endcase
  end

  // One shared add/sub unit serves S1..S3.
  assign sub  = (state == S3);
  assign opb  = (state == S2) ? cr : br;
  assign alu  = sub ? (ar - opb) : (ar + opb);
  assign gsel = dLTe ? d : e;
  assign shl  = 32'(h << dLTe);
  assign shr  = 32'(g >> dEQe);

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      ar   <= '0;
      br   <= '0;
      cr   <= '0;
      d    <= '0;
      e    <= '0;
      f    <= '0;
      g    <= '0;
      h    <= '0;
      dLTe <= 1'b0;
      dEQe <= 1'b0;
      z    <= '0;
      x    <= '0;
    end else begin
      unique case (state)
        WAIT: begin
          if (bus.Start) begin
            ar <= bus.a;
            br <= bus.b;
            cr <= bus.c;
          end
        end
        S1: d <= alu;
        S2: e <= alu;
        S3: begin
          f    <= alu;
          dLTe <= $signed(d) < $signed(e);
          dEQe <= (d == e);
        end
        // h must see the g being written this cycle.
        S4: begin
          g <= gsel;
          h <= dEQe ? gsel : f;
        end
        S5: begin
          x <= shl;
          z <= shr;
        end
        default: ;
      endcase
    end
  end

  assign bus.z    = z;
  assign bus.x    = x;
  assign bus.Done = (state == FINAL);

`ifdef CIRCUIT4_HLSM_BUSY_EN
  assign Busy = (state != WAIT);
`endif
endmodule

// File: tb/tb_circuit4_hlsm.sv
// Directed bench for circuit4_hlsm: reset, datapath vectors,
// truncation, abort-on-reset and back-to-back handshake.
module tb_circuit4_hlsm;
  logic Clk;
  logic Rst;
`ifdef CIRCUIT4_HLSM_BUSY_EN
  logic Busy;
`endif

  int passed;
  int total;
  int dn;

  circuit4_hlsm_if #(.DATAWIDTH(64)) bus ();

  circuit4_hlsm #(.DATAWIDTH(64)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
`ifdef CIRCUIT4_HLSM_BUSY_EN
    ,
    .Busy(Busy)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic run(input string tag,
                     input logic [63:0] ai,
                     input logic [63:0] bi,
                     input logic [63:0] ci,
                     input logic [31:0] xe,
                     input logic [31:0] ze);
    int lat;
    bus.a     = ai;
    bus.b     = bi;
    bus.c     = ci;
    bus.Start = 1'b1;
    tick();
    bus.Start = 1'b0;
    lat = 0;
    for (int n = 1; n <= 10; n++) begin
      tick();
      if (bus.Done === 1'b1) begin
        lat = n;
        break;
      end
    end
    check({tag, "_lat"}, 64'(lat), 64'd5);
    check({tag, "_x"}, 64'(bus.x), 64'(xe));
    check({tag, "_z"}, 64'(bus.z), 64'(ze));
    tick();
    check({tag, "_done_drop"}, 64'(bus.Done), 64'd0);
  endtask

  initial begin
    passed    = 0;
    total     = 0;
    Rst       = 1'b0;
    bus.Start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.c     = '0;
    #12;
    check("rst_z", 64'(bus.z), 64'd0);
    check("rst_x", 64'(bus.x), 64'd0);
    check("rst_done", 64'(bus.Done), 64'd0);
`ifdef CIRCUIT4_HLSM_BUSY_EN
    check("rst_busy", 64'(Busy), 64'd0);
`endif
    tick();
    Rst = 1'b1;

    run("v531", 64'd5, 64'd3, 64'd1, 32'h00000002, 32'h00000006);
    run("v111", 64'd1, 64'd1, 64'd1, 32'h00000002, 32'h00000001);
    run("vneg", 64'd0, 64'd1, 64'd5, 32'hFFFFFFFE, 32'h00000001);
    run("vtrunc", 64'h0000000100000003, 64'd0, 64'h10,
        32'h00000006, 32'h00000003);

    // Abort in S3 after a run left z/x non-zero.
    bus.a     = 64'd5;
    bus.b     = 64'd3;
    bus.c     = 64'd1;
    bus.Start = 1'b1;
    tick();
    bus.Start = 1'b0;
    tick();
    tick();
    #3;
    Rst = 1'b0;
    #1;
    check("abort_done", 64'(bus.Done), 64'd0);
    check("abort_z", 64'(bus.z), 64'd0);
    check("abort_x", 64'(bus.x), 64'd0);
`ifdef CIRCUIT4_HLSM_BUSY_EN
    check("abort_busy", 64'(Busy), 64'd0);
`endif
    tick();
    Rst = 1'b1;
    dn  = 0;
    for (int n = 0; n < 10; n++) begin
      tick();
      if (bus.Done === 1'b1) dn++;
    end
    check("abort_no_done", 64'(dn), 64'd0);

    // Start held across two runs; operands change while busy.
    bus.a     = 64'd5;
    bus.b     = 64'd3;
    bus.c     = 64'd1;
    bus.Start = 1'b1;
    tick();
    dn = 0;
    for (int n = 1; n <= 14; n++) begin
      tick();
      if (n == 1) begin
        bus.a = 64'd1;
        bus.b = 64'd1;
        bus.c = 64'd1;
      end
      if (n == 7) begin
        bus.Start = 1'b0;
        bus.a     = 64'd0;
        bus.b     = 64'd1;
        bus.c     = 64'd5;
      end
      if (bus.Done === 1'b1) dn++;
      check($sformatf("hs_done_%0d", n), 64'(bus.Done),
            64'((n == 5) || (n == 12)));
`ifdef CIRCUIT4_HLSM_BUSY_EN
      check($sformatf("hs_busy_%0d", n), 64'(Busy),
            64'(!((n == 6) || (n >= 13))));
`endif
      if (n == 5) begin
        check("hs1_x", 64'(bus.x), 64'h2);
        check("hs1_z", 64'(bus.z), 64'h6);
      end
      if (n == 12) begin
        check("hs2_x", 64'(bus.x), 64'h2);
        check("hs2_z", 64'(bus.z), 64'h1);
      end
    end
    check("hs_done_count", 64'(dn), 64'd2);
    check("hs_hold_x", 64'(bus.x), 64'h2);
    check("hs_hold_z", 64'(bus.z), 64'h1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
